move_list_streamer: RTL and testbench
=====================================

// Module: move_list_streamer
// PURPOSE
//  Synthesizable successor to the move-dump sequencer: once all_moves asserts am_moves_ready, walks am_move_index 0..count-1 and
//  emits one record per legal move over a valid/ready stream, then pulses am_clear_moves.
//  Sits between all_moves and the host/UCI output path; RAM read latency and the post-clear wait are parametrised.
// PARAMETERS
//  MAX_POSITIONS_LOG2  8   width of move index/count
//  UCI_WIDTH           16  {promotion[3:0], to_row, to_col, from_row, from_col}
//  EVAL_WIDTH          22  signed eval width
//  RD_LATENCY          2   cycles from am_move_index change to valid move data (>=1)
//  CLEAR_WAIT          2   cycles held in CLEAR_WAIT after the am_clear_moves pulse (>=1)
// PORTS
//  clk               in   1                   clock
//  reset             in   1                   async active-high reset
//  stream_en         in   1                   1: accept am_moves_ready; 0: stay in IDLE
//  abort             in   1                   abandon current list, go to CLEAR
//  am_moves_ready    in   1                   from all_moves: move list complete
//  am_move_count     in   MAX_POSITIONS_LOG2  number of moves
//  uci_in            in   UCI_WIDTH           move at am_move_index
//  eval_in           in   EVAL_WIDTH          eval at am_move_index
//  capture_in        in   1                   move is a capture
//  check_in          in   1                   white_in_check_out|black_in_check_out
//  init_flags_in     in   4                   {fifty, thrice_rep, stalemate, mate} for the root position
//  am_move_index     out  MAX_POSITIONS_LOG2  move RAM read address
//  am_clear_moves    out  1                   one-cycle clear pulse to all_moves
//  out_valid         out  1                   record valid
//  out_ready         in   1                   consumer accepts
//  out_index         out  MAX_POSITIONS_LOG2  move index of record
//  out_uci           out  UCI_WIDTH           move
//  out_eval          out  EVAL_WIDTH          eval
//  out_capture       out  1                   capture flag
//  out_check         out  1                   check flag
//  out_last          out  1                   final record of list
//  out_terminal      out  1                   record is terminal status, no move
//  out_flags         out  4                   init_flags_in latched at START
//  out_ascii         out  40                  "e7e8q" style text, MSB char first
//  busy              out  1                   state != IDLE
// BEHAVIOUR
//  Reset (async): all outputs 0, state IDLE.
//  IDLE: am_move_index=0; go START when stream_en & am_moves_ready.
//  START: latch count=am_move_count and flags=init_flags_in; count==0 -> TERMINAL, else ISSUE.
//  ISSUE: drive am_move_index=idx; load wait counter with RD_LATENCY; -> WAIT.
//  WAIT: decrement counter; at 0 capture the inputs into the out_* registers and set out_valid -> PRESENT.
//  PRESENT: hold out_* stable until out_valid&out_ready; then idx+1 -> ISSUE, or -> CLEAR if idx==count-1.
//    out_last=1 iff idx==count-1.
//  TERMINAL: one record with out_terminal=1, out_last=1, out_index/uci/eval/capture/check=0; on handshake -> CLEAR.
//  CLEAR: am_clear_moves=1 for exactly one cycle -> CLEAR_WAIT.
//  CLEAR_WAIT: CLEAR_WAIT cycles -> IDLE; am_moves_ready is ignored here.
//  abort in any state other than IDLE/CLEAR/CLEAR_WAIT: drop out_valid next cycle, -> CLEAR.
//    Abort together with a handshake: that record counts as transferred, no further records.
//  Worst-case per-move throughput: RD_LATENCY+2 cycles with out_ready held high.
//  Count is latched; max list is 2^MAX_POSITIONS_LOG2-1; idx never wraps.
//  Change on am_move_count after START has no effect.
//  stream_en deassert mid-list has no effect; it is sampled only in IDLE.
// CONFIGURATION
//  MOVE_STREAM_ASCII_EN defined:
//    out_ascii registered together with out_uci as {"a"+from_col, "1"+from_row, "a"+to_col, "1"+to_row, promo}.
//    promo: Q/R/B/N -> "q","r","b","n"; EMPTY -> " "; other codes -> "?".
//    Terminal record ascii = "-----".
//  Not defined: out_ascii tied to 40'h0; no ASCII logic synthesized.
// TESTING
//  Start position, 20 moves, out_ready=1:
//    20 records, indices 0..19, out_last only on 19; one am_clear_moves pulse; busy drops CLEAR_WAIT cycles later.
//  Checkmated root (count=0, flags=4'b0001):
//    single record out_terminal=1, out_last=1, out_flags=1; then clear pulse.
//  Backpressure: out_ready toggles every 3 cycles:
//    out_* stable while valid&!ready; no record lost or duplicated; RD_LATENCY=3 data matches am_move_index.
//  abort while PRESENT at idx 5 of 20: out_valid low next cycle, exactly one clear pulse, no idx 6.
//  Same-cycle abort+handshake at idx 5: idx 5 transferred, nothing further.
//  Async reset asserted in WAIT: all outputs 0 immediately; the next am_moves_ready restarts from idx 0.
//  ASCII_EN, white pawn e7->e8 promoting to queen: out_ascii="e7e8q"; without the macro: out_ascii=0.

Source files
------------

// File: rtl/move_list_streamer.sv
// rtl/move_list_streamer.sv - walks the all_moves move RAM and streams one record per legal move
// Optional feature macro: MOVE_STREAM_ASCII_EN (registers "e7e8q"-style text alongside each record).
// uci layout: [2:0] from_col, [5:3] from_row, [8:6] to_col, [11:9] to_row, [15:12] promotion.
// Promotion code: 4'h0 = EMPTY; low three bits 5/4/3/2 = queen/rook/bishop/knight (bit 3 = colour).
module move_list_streamer #(
  parameter int MAX_POSITIONS_LOG2 = 8,
  parameter int UCI_WIDTH          = 16,
  parameter int EVAL_WIDTH         = 22,
  parameter int RD_LATENCY         = 2,
  parameter int CLEAR_WAIT         = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stream_en,
  input  logic                          abort,
  input  logic                          am_moves_ready,
  input  logic [MAX_POSITIONS_LOG2-1:0] am_move_count,
  input  logic [UCI_WIDTH-1:0]          uci_in,
  input  logic [EVAL_WIDTH-1:0]         eval_in,
  input  logic                          capture_in,
  input  logic                          check_in,
  input  logic [3:0]                    init_flags_in,
  output logic [MAX_POSITIONS_LOG2-1:0] am_move_index,
  output logic                          am_clear_moves,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MAX_POSITIONS_LOG2-1:0] out_index,
  output logic [UCI_WIDTH-1:0]          out_uci,
  output logic [EVAL_WIDTH-1:0]         out_eval,
  output logic                          out_capture,
  output logic                          out_check,
  output logic                          out_last,
  output logic                          out_terminal,
  output logic [3:0]                    out_flags,
  output logic [39:0]                   out_ascii,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ISSUE, S_WAIT, S_PRESENT, S_TERMINAL, S_CLEAR, S_CLEAR_WAIT
  } state_t;

  // One shared down-counter serves both the read-latency wait and the post-clear wait.
  localparam int CNT_MAX = (RD_LATENCY > CLEAR_WAIT) ? RD_LATENCY : CLEAR_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LATENCY);
  localparam logic [CNT_W-1:0] CW_LOAD = CNT_W'(CLEAR_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                        state, state_nxt;
  logic [MAX_POSITIONS_LOG2-1:0] idx;
  logic [MAX_POSITIONS_LOG2-1:0] count;
  logic [CNT_W-1:0]              cnt;
  logic                          handshake;
  logic                          is_last;
  logic                          abort_ok;
  logic                          capture_now;
  logic                          term_load;

  assign handshake   = out_valid & out_ready;
  assign is_last     = (idx == count - 1'b1);
  assign abort_ok    = abort && (state != S_IDLE) && (state != S_CLEAR) && (state != S_CLEAR_WAIT);
  assign capture_now = (state == S_WAIT) && (cnt == CNT_ONE);
  assign term_load   = (state == S_START) && (am_move_count == '0);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; abort overrides every active state.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (stream_en && am_moves_ready) state_nxt = S_START;
      S_START:      state_nxt = (am_move_count == '0) ? S_TERMINAL : S_ISSUE;
      S_ISSUE:      state_nxt = S_WAIT;
      S_WAIT:       if (cnt == CNT_ONE) state_nxt = S_PRESENT;
      S_PRESENT:    if (handshake) state_nxt = is_last ? S_CLEAR : S_ISSUE;
      S_TERMINAL:   if (handshake) state_nxt = S_CLEAR;
      S_CLEAR:      state_nxt = S_CLEAR_WAIT;
      S_CLEAR_WAIT: if (cnt == CNT_ONE) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
    if (abort_ok) state_nxt = S_CLEAR;
  end

  // Outputs decoded from the registered state; the read address is the index register itself.
  always_comb begin
    out_valid      = (state == S_PRESENT) || (state == S_TERMINAL);
    am_clear_moves = (state == S_CLEAR);
    busy           = (state != S_IDLE);
    am_move_index  = idx;
  end

  // Index, latched count and wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx   <= '0;
      count <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE:       idx <= '0;
        S_START: begin
          idx   <= '0;
          count <= am_move_count;
        end
        S_ISSUE:      cnt <= RD_LOAD;
        S_WAIT:       cnt <= cnt - CNT_ONE;
        S_PRESENT:    if (handshake && !is_last && !abort) idx <= idx + 1'b1;
        S_CLEAR: begin
          idx <= '0;
          cnt <= CW_LOAD;
        end
        S_CLEAR_WAIT: cnt <= cnt - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Output record: loaded once per move when the read latency expires, or as the terminal record.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_index    <= '0;
      out_uci      <= '0;
      out_eval     <= '0;
      out_capture  <= 1'b0;
      out_check    <= 1'b0;
      out_last     <= 1'b0;
      out_terminal <= 1'b0;
      out_flags    <= 4'h0;
    end else begin
      if (state == S_START) out_flags <= init_flags_in;
      if (term_load) begin
        out_index    <= '0;
        out_uci      <= '0;
        out_eval     <= '0;
        out_capture  <= 1'b0;
        out_check    <= 1'b0;
        out_last     <= 1'b1;
        out_terminal <= 1'b1;
      end else if (capture_now) begin
        out_index    <= idx;
        out_uci      <= uci_in;
        out_eval     <= eval_in;
        out_capture  <= capture_in;
        out_check    <= check_in;
        out_last     <= is_last;
        out_terminal <= 1'b0;
      end
    end
  end

`ifdef MOVE_STREAM_ASCII_EN
  logic [39:0] ascii_q;

  function automatic logic [7:0] promo_char(input logic [3:0] p);
    logic [7:0] c;
    case (p[2:0])
      3'd5:    c = "q";
      3'd4:    c = "r";
      3'd3:    c = "b";
      3'd2:    c = "n";
      default: c = (p == 4'h0) ? " " : "?";
    endcase
    return c;
  endfunction

  function automatic logic [39:0] uci_text(input logic [15:0] u);
    return {8'h61 + {5'b0, u[2:0]}, 8'h31 + {5'b0, u[5:3]},
            8'h61 + {5'b0, u[8:6]}, 8'h31 + {5'b0, u[11:9]}, promo_char(u[15:12])};
  endfunction

  // Text is registered on the same edge as out_uci so the two never disagree.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            ascii_q <= 40'h0;
    else if (term_load)   ascii_q <= "-----";
    else if (capture_now) ascii_q <= uci_text(uci_in[15:0]);
  end

  assign out_ascii = ascii_q;
`else
  assign out_ascii = 40'h0;
`endif

endmodule

// File: tb/tb_move_list_streamer.sv
// tb/tb_move_list_streamer.sv - directed table-driven bench for move_list_streamer
module tb_move_list_streamer;

  localparam int LAT = 3;
  localparam int CW  = 2;

`ifdef MOVE_STREAM_ASCII_EN
  localparam logic [39:0] ASC_Q = "e7e8q";
  localparam logic [39:0] ASC_T = "-----";
`else
  localparam logic [39:0] ASC_Q = 40'h0;
  localparam logic [39:0] ASC_T = 40'h0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stream_en = 1'b0;
  logic        abort = 1'b0;
  logic        am_moves_ready = 1'b0;
  logic [7:0]  am_move_count = 8'h0;
  logic [15:0] uci_in;
  logic [21:0] eval_in;
  logic        capture_in;
  logic        check_in;
  logic [3:0]  init_flags_in = 4'h0;
  logic [7:0]  am_move_index;
  logic        am_clear_moves;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_index;
  logic [15:0] out_uci;
  logic [21:0] out_eval;
  logic        out_capture;
  logic        out_check;
  logic        out_last;
  logic        out_terminal;
  logic [3:0]  out_flags;
  logic [39:0] out_ascii;
  logic        busy;

  int checks = 0;
  int errors = 0;

  move_list_streamer #(.MAX_POSITIONS_LOG2(8), .UCI_WIDTH(16), .EVAL_WIDTH(22),
                       .RD_LATENCY(LAT), .CLEAR_WAIT(CW)) dut (
    .clk(clk), .reset(reset), .stream_en(stream_en), .abort(abort),
    .am_moves_ready(am_moves_ready), .am_move_count(am_move_count),
    .uci_in(uci_in), .eval_in(eval_in), .capture_in(capture_in), .check_in(check_in),
    .init_flags_in(init_flags_in), .am_move_index(am_move_index),
    .am_clear_moves(am_clear_moves), .out_valid(out_valid), .out_ready(out_ready),
    .out_index(out_index), .out_uci(out_uci), .out_eval(out_eval),
    .out_capture(out_capture), .out_check(out_check), .out_last(out_last),
    .out_terminal(out_terminal), .out_flags(out_flags), .out_ascii(out_ascii), .busy(busy)
  );

  always #5 clk = ~clk;

  // Move RAM model: data follows the address after LAT clock edges.
  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= am_move_index;
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  function automatic logic [15:0] m_uci(input logic [7:0] i);
    return (i == 8'd3) ? 16'h5F34 : {8'h0A, i};
  endfunction
  function automatic logic [21:0] m_eval(input logic [7:0] i);
    return 22'(int'(i) * 1000 - 5000);
  endfunction

  assign uci_in     = m_uci(pipe[LAT-1]);
  assign eval_in    = m_eval(pipe[LAT-1]);
  assign capture_in = pipe[LAT-1][0];
  assign check_in   = pipe[LAT-1][2];

  logic [127:0] outs_all;
  assign outs_all = {23'h0, am_move_index, am_clear_moves, out_valid, out_index, out_uci, out_eval,
                     out_capture, out_check, out_last, out_terminal, out_flags, out_ascii, busy};

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic run_list(input int cnt_in, input logic [3:0] flg, input int mode,
                          input int abort_at, input bit abort_hs, input int exp_recs);
    int cyc, exp_idx, clears, clear_cyc, last_hs, done_cyc;
    bit started, done, prev_stall, abort_done, abort_chk;
    logic [127:0] rec, prev_rec, exp_rec;
    logic [7:0] e8;
    logic lst;
    cyc = 0; exp_idx = 0; clears = 0; clear_cyc = 0; last_hs = 0; done_cyc = 0;
    started = 0; done = 0; prev_stall = 0; abort_done = 0; abort_chk = 0;
    prev_rec = '0;
    @(negedge clk);
    am_move_count = cnt_in[7:0]; init_flags_in = flg;
    stream_en = 1'b1; am_moves_ready = 1'b1; out_ready = 1'b0; abort = 1'b0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      rec = {74'h0, out_terminal, out_last, out_check, out_capture, out_flags,
             out_index, out_uci, out_eval};
      if (abort_chk) begin
        check_int("abort_drop_valid", int'(out_valid), 0);
        abort_chk = 0;
      end
      abort = 1'b0;
      if (started) begin
        stream_en = 1'b0;
        am_move_count = 8'd7;
        init_flags_in = ~flg;
      end
      if (busy) started = 1;
      out_ready = (mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
      if (abort_at >= 0 && !abort_done && out_valid && !out_terminal && int'(out_index) == abort_at) begin
        abort = 1'b1; out_ready = abort_hs; abort_done = 1; abort_chk = 1;
      end
      if (prev_stall) check_vec("hold_stable", {out_valid, rec[126:0]}, {1'b1, prev_rec[126:0]});
      prev_stall = out_valid && !out_ready && !abort;
      prev_rec = rec;
      if (out_valid && out_ready) begin
        e8 = exp_idx[7:0];
        if (cnt_in == 0) begin
          exp_rec = {74'h0, 1'b1, 1'b1, 1'b0, 1'b0, flg, 8'h0, 16'h0, 22'h0};
          check_vec("terminal_rec", rec, exp_rec);
          check_vec("terminal_ascii", {88'h0, out_ascii}, {88'h0, ASC_T});
        end else begin
          lst = (exp_idx == cnt_in - 1);
          exp_rec = {74'h0, 1'b0, lst, e8[2], e8[0], flg, e8, m_uci(e8), m_eval(e8)};
          check_vec("move_rec", rec, exp_rec);
          if (exp_idx == 3) check_vec("ascii_e7e8q", {88'h0, out_ascii}, {88'h0, ASC_Q});
          if (mode == 0 && exp_idx > 0) check_int("throughput_gap", cyc - last_hs, LAT + 2);
        end
        last_hs = cyc;
        exp_idx++;
      end
      if (am_clear_moves) begin
        clears++;
        clear_cyc = cyc;
      end
      if (started && !busy) begin
        done = 1;
        done_cyc = cyc;
      end
    end
    check_int("list_timeout", int'(done), 1);
    check_int("record_count", exp_idx, exp_recs);
    check_int("clear_pulses", clears, 1);
    check_int("clear_wait_len", done_cyc - clear_cyc - 1, CW);
    am_moves_ready = 1'b0; out_ready = 1'b0;
  endtask

  typedef struct {
    int         count;
    logic [3:0] flags;
    int         mode;
    int         abort_at;
    bit         abort_hs;
    int         exp_recs;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int hs, k;
    vecs[0] = '{20, 4'b0000, 0, -1, 1'b0, 20};
    vecs[1] = '{0,  4'b0001, 0, -1, 1'b0, 1};
    vecs[2] = '{20, 4'b0100, 1, -1, 1'b0, 20};
    vecs[3] = '{20, 4'b0000, 0, 5,  1'b0, 5};
    vecs[4] = '{20, 4'b1000, 0, 5,  1'b1, 6};
    vecs[5] = '{1,  4'b1010, 1, -1, 1'b0, 1};

    repeat (4) @(negedge clk);
    check_vec("reset_outputs", outs_all, '0);
    reset = 1'b0;

    for (int v = 0; v < 6; v++)
      run_list(vecs[v].count, vecs[v].flags, vecs[v].mode,
               vecs[v].abort_at, vecs[v].abort_hs, vecs[v].exp_recs);

    // stream_en low keeps the block idle even with a ready list.
    @(negedge clk);
    stream_en = 1'b0; am_moves_ready = 1'b1; am_move_count = 8'd4;
    repeat (5) @(negedge clk);
    check_int("idle_without_en", int'(busy), 0);
    am_moves_ready = 1'b0;

    // Async reset while waiting on the RAM for idx 3, then a fresh list restarts at idx 0.
    @(negedge clk);
    am_move_count = 8'd20; init_flags_in = 4'b0011; stream_en = 1'b1;
    am_moves_ready = 1'b1; out_ready = 1'b1;
    hs = 0; k = 0;
    while (hs < 3 && k < 200) begin
      @(negedge clk);
      k++;
      stream_en = 1'b0;
      if (out_valid && out_ready) hs++;
    end
    check_int("pre_reset_records", hs, 3);
    @(negedge clk);
    @(negedge clk);
    check_int("wait_index", int'(am_move_index), 3);
    check_int("wait_busy_novalid", int'({busy, out_valid}), 2);
    reset = 1'b1;
    #1;
    check_vec("reset_in_wait", outs_all, '0);
    @(negedge clk);
    reset = 1'b0; am_moves_ready = 1'b0; out_ready = 1'b0;
    run_list(4, 4'b0010, 0, -1, 1'b0, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
